// File: rtl/univ_load_register.sv
// Universal load register: parallel load, shift/rotate, count and clear with
// registered serial-out and wrap flags. Optional registered parity output under ULR_PARITY_EN.
module univ_load_register #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             Load,
  input  logic [WIDTH-1:0] inp,
  input  logic [2:0]       mode,
  input  logic             sin,
`ifdef ULR_PARITY_EN
  output logic             parity,
`endif
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             carry,
  output logic             zero
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_INC  = 3'b101;
  localparam logic [2:0] MODE_DEC  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [WIDTH-1:0] out_q, out_d;
  logic             sout_q, sout_d;
  logic             carry_q, carry_d;

  // Next-state selection: Load wins over mode; carry defaults low on every enabled edge.
  always_comb begin
    out_d   = out_q;
    sout_d  = sout_q;
    carry_d = 1'b0;
    if (Load) begin
      out_d = inp;
    end else begin
      case (mode)
        MODE_HOLD: out_d = out_q;
        MODE_SHL: begin
          out_d  = {out_q[WIDTH-2:0], sin};
          sout_d = out_q[WIDTH-1];
        end
        MODE_SHR: begin
          out_d  = {sin, out_q[WIDTH-1:1]};
          sout_d = out_q[0];
        end
        MODE_ROL: begin
          out_d  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
          sout_d = out_q[WIDTH-1];
        end
        MODE_ROR: begin
          out_d  = {out_q[0], out_q[WIDTH-1:1]};
          sout_d = out_q[0];
        end
        MODE_INC: begin
          out_d   = out_q + ONE_W;
          carry_d = &out_q;
        end
        MODE_DEC: begin
          out_d   = out_q - ONE_W;
          carry_d = ~|out_q;
        end
        MODE_CLR: out_d = ZERO_W;
        default:  out_d = out_q;
      endcase
    end
  end

  // State register: async reset, otherwise update only on enabled edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= RST_VAL;
      sout_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (en) begin
      out_q   <= out_d;
      sout_q  <= sout_d;
      carry_q <= carry_d;
    end
  end

`ifdef ULR_PARITY_EN
  logic parity_q;

  // Parity tracks out in lockstep so it never lags the register contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= even_parity(RST_VAL);
    end else if (en) begin
      parity_q <= even_parity(out_d);
    end
  end

  assign parity = parity_q;
`endif

  assign out   = out_q;
  assign sout  = sout_q;
  assign carry = carry_q;
  assign zero  = (out_q == ZERO_W);

endmodule

// File: tb/tb_univ_load_register.sv
// Randomized self-checking bench for univ_load_register: two instances (RST_VAL 0 and 0101)
// share stimulus and are compared against an arithmetic reference model.
module tb_univ_load_register;

  logic       clk = 1'b0;
  logic       rst, en, Load, sin;
  logic [3:0] inp;
  logic [2:0] mode;
  logic [3:0] out_a, out_b;
  logic       sout_a, sout_b, carry_a, carry_b, zero_a, zero_b;
`ifdef ULR_PARITY_EN
  logic       par_a, par_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int m_out[2];
  int m_sout[2];
  int m_carry[2];
  int rv[2] = '{0, 5};

  always #5 clk = ~clk;

  univ_load_register #(.WIDTH(4), .RST_VAL(4'b0000)) dut_a (
    .clk(clk), .rst(rst), .en(en), .Load(Load), .inp(inp), .mode(mode), .sin(sin),
`ifdef ULR_PARITY_EN
    .parity(par_a),
`endif
    .out(out_a), .sout(sout_a), .carry(carry_a), .zero(zero_a)
  );

  univ_load_register #(.WIDTH(4), .RST_VAL(4'b0101)) dut_b (
    .clk(clk), .rst(rst), .en(en), .Load(Load), .inp(inp), .mode(mode), .sin(sin),
`ifdef ULR_PARITY_EN
    .parity(par_b),
`endif
    .out(out_b), .sout(sout_b), .carry(carry_b), .zero(zero_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int par4(input int v);
    return (v % 2 + (v / 2) % 2 + (v / 4) % 2 + (v / 8) % 2) % 2;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = rv[i];
      m_sout[i] = 0;
      m_carry[i] = 0;
    end
  endfunction

  // Reference behaviour on one enabled edge, written as plain arithmetic on 0..15.
  function automatic void model_step();
    int o;
    if (!en) return;
    for (int i = 0; i < 2; i++) begin
      o = m_out[i];
      m_carry[i] = 0;
      if (Load) begin
        m_out[i] = int'(inp);
      end else begin
        case (int'(mode))
          1: begin m_out[i] = (o * 2) % 16 + int'(sin); m_sout[i] = o / 8; end
          2: begin m_out[i] = int'(sin) * 8 + o / 2;    m_sout[i] = o % 2; end
          3: begin m_out[i] = (o * 2) % 16 + o / 8;     m_sout[i] = o / 8; end
          4: begin m_out[i] = (o % 2) * 8 + o / 2;      m_sout[i] = o % 2; end
          5: begin m_out[i] = (o + 1) % 16;  m_carry[i] = (o == 15) ? 1 : 0; end
          6: begin m_out[i] = (o + 15) % 16; m_carry[i] = (o == 0) ? 1 : 0; end
          7: m_out[i] = 0;
          default: m_out[i] = o;
        endcase
      end
    end
  endfunction

  task automatic check_outputs();
    check_eq("out_a",   out_a,   m_out[0]);
    check_eq("sout_a",  sout_a,  m_sout[0]);
    check_eq("carry_a", carry_a, m_carry[0]);
    check_eq("zero_a",  zero_a,  (m_out[0] == 0) ? 1 : 0);
    check_eq("out_b",   out_b,   m_out[1]);
    check_eq("sout_b",  sout_b,  m_sout[1]);
    check_eq("carry_b", carry_b, m_carry[1]);
    check_eq("zero_b",  zero_b,  (m_out[1] == 0) ? 1 : 0);
`ifdef ULR_PARITY_EN
    check_eq("par_a", par_a, par4(m_out[0]));
    check_eq("par_b", par_b, par4(m_out[1]));
`endif
  endtask

  // Apply one set of inputs for one clock edge, then compare on the falling edge.
  task automatic cycle(input bit e, input bit l, input int d, input int md, input bit s);
    en = e; Load = l; inp = d[3:0]; mode = md[2:0]; sin = s;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset pulse starting mid-low-phase while an increment is requested.
  task automatic pulse_reset();
    en = 1'b1; Load = 1'b0; mode = 3'b101;
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    #1 check_outputs();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; Load = 1'b0; inp = 4'h0; mode = 3'b000; sin = 1'b0;
    model_reset();
    #1 check_outputs();
    check_eq("rst_zero_a", zero_a, 1);
    @(negedge clk);
    rst = 1'b0;

    cycle(1, 1, 4'b0111, 0, 0);
    check_eq("load_0111", out_a, 4'b0111);
    cycle(1, 0, 0, 1, 1);
    check_eq("shl_out", out_a, 4'b1111);
    check_eq("shl_sout", sout_a, 0);
    cycle(1, 0, 0, 2, 0);
    check_eq("shr_out", out_a, 4'b0111);
    check_eq("shr_sout", sout_a, 1);

    cycle(1, 1, 4'b1111, 0, 0);
    cycle(1, 0, 0, 5, 0);
    check_eq("inc_wrap_out", out_a, 4'b0000);
    check_eq("inc_wrap_carry", carry_a, 1);
    check_eq("inc_wrap_zero", zero_a, 1);
    cycle(1, 0, 0, 5, 0);
    check_eq("inc_next_out", out_a, 4'b0001);
    check_eq("inc_next_carry", carry_a, 0);

    cycle(1, 1, 4'b0000, 0, 0);
    cycle(1, 0, 0, 6, 0);
    check_eq("dec_wrap_out", out_a, 4'b1111);
    check_eq("dec_wrap_carry", carry_a, 1);
    cycle(1, 1, 4'b1001, 0, 0);
    cycle(1, 0, 0, 3, 0);
    check_eq("rol_out", out_a, 4'b0011);
    check_eq("rol_sout", sout_a, 1);

    cycle(1, 1, 4'b1111, 0, 0);
    cycle(1, 0, 0, 5, 0);
    cycle(1, 1, 4'b1010, 7, 0);
    check_eq("load_over_clr", out_a, 4'b1010);
    check_eq("load_carry_low", carry_a, 0);
    cycle(1, 1, 4'b1111, 0, 0);
    cycle(1, 0, 0, 5, 0);
    cycle(0, 0, 0, 5, 0);
    check_eq("en0_hold_out", out_a, 4'b0000);
    check_eq("en0_hold_carry", carry_a, 1);

    cycle(1, 0, 0, 5, 0);
    cycle(1, 0, 0, 5, 0);
    pulse_reset();
    check_eq("rst_val_b", out_b, 4'b0101);
    cycle(1, 1, 4'b0111, 0, 0);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulse_reset();
      end else begin
        cycle($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
              int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
              $urandom_range(0, 1) == 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/univ_load_register.md
UNIV_LOAD_REGISTER -- requirements
Module: univ_load_register

Interface
REQ-001 Parameter WIDTH, default 4, data width in bits; legal range 2..32.
REQ-002 Parameter RST_VAL, default 0, value `out` takes on reset; WIDTH bits wide.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port en  input  1  clock enable; 0 = all state holds.
REQ-006 Port Load  input  1  parallel load request; has priority over `mode`.
REQ-007 Port inp  input  WIDTH  parallel load data.
REQ-008 Port mode  input  3  operation select when Load=0.
REQ-009 Port sin  input  1  serial input bit for shift modes.
REQ-010 Port out  output  WIDTH  register contents.
REQ-011 Port sout  output  1  last bit shifted or rotated out; registered.
REQ-012 Port carry  output  1  one-cycle wrap flag for count modes; registered.
REQ-013 Port zero  output  1  high when out == 0; combinational from the register.

Function
REQ-014 Operation is evaluated at each rising clk edge with rst=0 and en=1; with en=0, out, sout and carry all hold.
REQ-015 Priority order: rst, then en=0 (hold), then Load=1 (out <= inp), then mode.
REQ-016 mode 000 hold: out unchanged.
REQ-017 mode 001 shift left: out <= {out[WIDTH-2:0], sin}; sout <= old out[WIDTH-1].
REQ-018 mode 010 shift right: out <= {sin, out[WIDTH-1:1]}; sout <= old out[0].
REQ-019 mode 011 rotate left: out <= {out[WIDTH-2:0], out[WIDTH-1]}; sout <= old out[WIDTH-1].
REQ-020 mode 100 rotate right: out <= {out[0], out[WIDTH-1:1]}; sout <= old out[0].
REQ-021 mode 101 increment: out <= out+1 modulo 2^WIDTH; carry <= 1 only when old out is all ones.
REQ-022 mode 110 decrement: out <= out-1 modulo 2^WIDTH; carry <= 1 only when old out is 0.
REQ-023 mode 111 clear: out <= 0, independent of RST_VAL.
REQ-024 sout updates only in modes 001-100; otherwise it holds, including during Load.
REQ-025 carry is 0 after every enabled edge that is not a wrapping increment or decrement, so it is high for exactly one enabled cycle per wrap.
REQ-026 A Load and a mode request in the same cycle perform the Load only; carry <= 0 on that edge.
REQ-027 Latency: out reflects the operation one clk edge after it is sampled; zero follows out with no added cycle.

Reset
REQ-028 While rst=1: out = RST_VAL, sout = 0, carry = 0, applied immediately and without a clock edge.
REQ-029 Reset asserted mid-operation overrides any Load, en or mode in progress; no partial update is retained.
REQ-030 Deassertion of rst takes effect on the first rising clk edge after release; no operation is performed on the release itself.

Configuration
REQ-031 Macro ULR_PARITY_EN: when defined, output port `parity` (1 bit) is present and equals the even parity (XOR reduction) of out, registered alongside out, with reset value equal to the parity of RST_VAL.
REQ-032 Without ULR_PARITY_EN, the `parity` port and its logic are absent and all other behaviour is identical.

Verification
REQ-033 WIDTH=4, RST_VAL=0: pulse rst between clock edges -> out=0000, sout=0, carry=0 immediately; zero=1.
REQ-034 Load=1 with inp=0111, then mode=001 with sin=1 -> out=0111, then 1111 with sout=0; mode=010 with sin=0 -> out=0111, sout=1.
REQ-035 Load 1111, then mode=101 -> out=0000, carry=1 for one cycle, zero=1; next increment -> out=0001, carry=0.
REQ-036 Load 0000, then mode=110 -> out=1111, carry=1; mode=011 on 1001 -> out=0011, sout=1.
REQ-037 Load=1 with inp=1010 and mode=111 in the same cycle -> out=1010; en=0 with mode=101 -> out holds at 1010 and carry holds.
REQ-038 Assert rst mid-stream during an increment sequence with RST_VAL=0101 -> out=0101 immediately; with ULR_PARITY_EN defined, parity=0 after reset and parity=1 after loading 0111.
